// File: rtl/alien_fleet_pkg.sv
// Shared constants and state encoding for the alien fleet block and its
// sprite scan helper.
package alien_fleet_pkg;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] DRAW_COLOUR = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    ERASE,
    DONE
  } fleet_state_t;
endpackage

// File: rtl/alien_fleet_if.sv
// Game-control / VGA facing signal bundle of the alien fleet.
interface alien_fleet_if
  import alien_fleet_pkg::*;
#(
  parameter int NUM_ALIENS = 4
) ();
  logic                  move;
  logic                  draw_req;
  logic                  erase_req;
  logic                  bullet_valid;
  logic [X_W-1:0]        bullet_x;
  logic [Y_W-1:0]        bullet_y;
  logic [X_W-1:0]        x;
  logic [Y_W-1:0]        y;
  logic [2:0]            colour;
  logic                  plot;
  logic                  busy;
  logic                  done;
  logic                  hit;
  logic [3:0]            hit_index;
  logic [NUM_ALIENS-1:0] alive;
  logic                  all_dead;
  logic                  reached_bottom;

  modport master (
    output move, draw_req, erase_req, bullet_valid, bullet_x, bullet_y,
    input  x, y, colour, plot, busy, done, hit, hit_index, alive, all_dead,
           reached_bottom
  );

  modport slave (
    input  move, draw_req, erase_req, bullet_valid, bullet_x, bullet_y,
    output x, y, colour, plot, busy, done, hit, hit_index, alive, all_dead,
           reached_bottom
  );
endinterface

// File: rtl/alien_fleet_sprite_pixel_scan.sv
// Row-major pixel walker over one SPRITE_W x SPRITE_H sprite; a start pulse
// reloads the origin, so back-to-back sprites need no idle cycle.
module sprite_pixel_scan
  import alien_fleet_pkg::*;
#(
  parameter int SPRITE_W = 10,
  parameter int SPRITE_H = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] origin_x,
  input  logic [Y_W-1:0] origin_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           valid,
  output logic           last
);
  localparam int CW = $clog2(SPRITE_W + 1);
  localparam int RW = $clog2(SPRITE_H + 1);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [X_W-1:0] base_x;

  assign last = valid && (col == CW'(SPRITE_W - 1)) && (row == RW'(SPRITE_H - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      x      <= '0;
      y      <= '0;
      valid  <= 1'b0;
      col    <= '0;
      row    <= '0;
      base_x <= '0;
    end else if (start) begin
      x      <= origin_x;
      y      <= origin_y;
      base_x <= origin_x;
      col    <= '0;
      row    <= '0;
      valid  <= 1'b1;
    end else if (valid) begin
      if (last) begin
        valid <= 1'b0;
      end else if (col == CW'(SPRITE_W - 1)) begin
        col <= '0;
        row <= row + RW'(1);
        x   <= base_x;
        y   <= y + Y_W'(1);
      end else begin
        col <= col + CW'(1);
        x   <= x + X_W'(1);
      end
    end
  end
endmodule

// File: rtl/alien_fleet.sv
// Marching row of aliens: edge-bounce movement, bullet collision and
// per-alien draw/erase passes streamed through one pixel port.
//   state | meaning
//   IDLE  | accepts move, bullets, draw/erase requests
//   DRAW  | scanning aliens, plotting live ones in DRAW_COLOUR
//   ERASE | scanning aliens, blanking live or dying ones
//   DONE  | one-cycle done pulse, back to IDLE
module alien_fleet
  import alien_fleet_pkg::*;
#(
  parameter int         NUM_ALIENS  = 4,
  parameter int         SPRITE_W    = 10,
  parameter int         SPRITE_H    = 4,
  parameter int         SPACING     = 16,
  parameter int         SCREEN_W    = alien_fleet_pkg::SCREEN_W,
  parameter int         SCREEN_H    = alien_fleet_pkg::SCREEN_H,
  parameter int         STEP_Y      = 1,
  parameter logic [2:0] DRAW_COLOUR = alien_fleet_pkg::DRAW_COLOUR
) (
  input logic        clk,
  input logic        reset,
  alien_fleet_if.slave bus
);
  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
  localparam int SPAN = (NUM_ALIENS - 1) * SPACING + SPRITE_W - 1;
  localparam int Y_MAX = SCREEN_H - SPRITE_H;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ALIENS - 1);

  fleet_state_t          state, state_nx;
  logic [X_W-1:0]        fleet_x, fleet_x_nx;
  logic [Y_W-1:0]        fleet_y, fleet_y_nx;
  logic                  dir_right, dir_nx;
  logic [NUM_ALIENS-1:0] alive, dying, hit_mask;
  logic [3:0]            idx, idx_nx, scan_sel, hit_sel, hit_index_r;
  logic                  scan_start, scan_valid, scan_last, pass_end;
  logic                  hit_found, hit_r, busy_r, done_r;
  logic [2:0]            colour_r;
  logic [X_W-1:0]        scan_x, scan_ox;
  logic [Y_W-1:0]        scan_y;
  logic [15:0]           elig_draw, elig_erase;
  logic [XW1-1:0]        right_edge, ox, bx;
  logic [YW1-1:0]        y_step, by, fy;

  assign elig_draw  = 16'(alive);
  assign elig_erase = 16'(alive | dying);
  assign scan_ox    = fleet_x + X_W'(int'(scan_sel) * SPACING);

  sprite_pixel_scan #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start    (scan_start),
    .origin_x (scan_ox),
    .origin_y (fleet_y),
    .x        (scan_x),
    .y        (scan_y),
    .valid    (scan_valid),
    .last     (scan_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // An alien slot ends on its last pixel, or after one blank cycle if skipped.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    scan_sel   = idx;
    scan_start = 1'b0;
    pass_end   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.erase_req) begin
          state_nx   = ERASE;
          idx_nx     = '0;
          scan_sel   = '0;
          scan_start = elig_erase[0];
        end else if (bus.draw_req) begin
          state_nx   = DRAW;
          idx_nx     = '0;
          scan_sel   = '0;
          scan_start = elig_draw[0];
        end
      end
      DRAW, ERASE: begin
        if (scan_last || !scan_valid) begin
          if (idx == LAST_IDX) begin
            state_nx = DONE;
            pass_end = 1'b1;
          end else begin
            idx_nx     = idx + 4'd1;
            scan_sel   = idx + 4'd1;
            scan_start = (state == ERASE) ? elig_erase[scan_sel] : elig_draw[scan_sel];
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    right_edge = {1'b0, fleet_x} + XW1'(SPAN);
    y_step     = {1'b0, fleet_y} + YW1'(STEP_Y);
    fleet_x_nx = fleet_x;
    fleet_y_nx = fleet_y;
    dir_nx     = dir_right;
    if ((dir_right && right_edge == XW1'(SCREEN_W - 1)) || (!dir_right && fleet_x == '0)) begin
      fleet_y_nx = (y_step > YW1'(Y_MAX)) ? Y_W'(Y_MAX) : y_step[Y_W-1:0];
      dir_nx     = !dir_right;
    end else if (dir_right) begin
      fleet_x_nx = fleet_x + X_W'(1);
    end else begin
      fleet_x_nx = fleet_x - X_W'(1);
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_found = 1'b0;
    hit_sel   = '0;
    hit_mask  = '0;
    ox        = '0;
    bx        = {1'b0, bus.bullet_x};
    by        = {1'b0, bus.bullet_y};
    fy        = {1'b0, fleet_y};
    if (state == IDLE && bus.bullet_valid) begin
      for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
        ox = {1'b0, fleet_x} + XW1'(i * SPACING);
        if (alive[i] && bx >= ox && bx <= ox + XW1'(SPRITE_W - 1) &&
            by >= fy && by <= fy + YW1'(SPRITE_H - 1)) begin
          hit_found   = 1'b1;
          hit_sel     = 4'(i);
          hit_mask    = '0;
          hit_mask[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fleet_x     <= '0;
      fleet_y     <= '0;
      dir_right   <= 1'b1;
      alive       <= '1;
      dying       <= '0;
      idx         <= '0;
      hit_r       <= 1'b0;
      hit_index_r <= '0;
      colour_r    <= COLOUR_BLACK;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      idx    <= idx_nx;
      hit_r  <= hit_found;
      busy_r <= (state_nx == DRAW) || (state_nx == ERASE);
      done_r <= (state_nx == DONE);
      if (state == IDLE && bus.move) begin
        fleet_x   <= fleet_x_nx;
        fleet_y   <= fleet_y_nx;
        dir_right <= dir_nx;
      end
      if (hit_found) begin
        hit_index_r <= hit_sel;
        alive       <= alive & ~hit_mask;
      end
      if (pass_end && state == ERASE) dying <= '0;
      else                            dying <= dying | hit_mask;
      if (state == IDLE && (bus.erase_req || bus.draw_req))
        colour_r <= bus.erase_req ? COLOUR_BLACK : DRAW_COLOUR;
    end
  end

  assign bus.x              = scan_x;
  assign bus.y              = scan_y;
  assign bus.plot           = scan_valid;
  assign bus.colour         = colour_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.hit            = hit_r;
  assign bus.hit_index      = hit_index_r;
  assign bus.alive          = alive;
  assign bus.all_dead       = (alive == '0);
  assign bus.reached_bottom = ({1'b0, fleet_y} + YW1'(SPRITE_H)) >= YW1'(SCREEN_H);
endmodule

// File: doc/alien_fleet.md
Name: alien_fleet

Overview:
- Parametrised successor to the single-alien sprite block. Manages a horizontal row of NUM_ALIENS aliens that march together: left/right sweep, step down at each screen edge, per-alien alive state, bullet collision with hit reporting.
- Streams draw/erase pixels to the VGA adapter through one pixel port.
- Sits between the game-control FSM, which issues move/draw/erase requests, and the VGA adapter.

Parameters:
NUM_ALIENS, 4, aliens in the row (1..16)
SPRITE_W, 10, sprite width in pixels
SPRITE_H, 4, sprite height in pixels
SPACING, 16, x pitch between alien origins (must be >= SPRITE_W)
SCREEN_W, 320, visible width
SCREEN_H, 240, visible height
STEP_Y, 1, rows descended at each edge bounce
DRAW_COLOUR, 3'b101, colour for draw passes (erase is always 3'b000)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
move  in  1  pulse: advance the fleet one step
draw_req  in  1  pulse: start a draw pass
erase_req  in  1  pulse: start an erase pass
bullet_valid  in  1  bullet coordinates valid
bullet_x  in  9  bullet x
bullet_y  in  8  bullet y
x  out  9  pixel x
y  out  8  pixel y
colour  out  3  pixel colour
plot  out  1  pixel write enable
busy  out  1  pass in progress
done  out  1  1-cycle pulse at end of a pass
hit  out  1  1-cycle pulse on a collision
hit_index  out  4  index of the alien hit (held until the next hit)
alive  out  NUM_ALIENS  alive mask
all_dead  out  1  alive == 0
reached_bottom  out  1  fleet_y + SPRITE_H >= SCREEN_H

Behaviour:
- Reset (reset=0 at a clk edge):
  - fleet_x=0, fleet_y=0, direction=right, alive=all ones, dying=0.
  - x, y, colour, plot, busy, done, hit, hit_index all 0; state IDLE.
  - Reset mid-pass aborts the pass; plot is 0 from the next cycle.
- Alien i origin: (fleet_x + i*SPACING, fleet_y). Fleet right edge R = fleet_x + (NUM_ALIENS-1)*SPACING + SPRITE_W - 1.
- Move (sampled in IDLE only; ignored while busy, not queued):
  - Right with R == SCREEN_W-1: fleet_y += STEP_Y, direction flips to left, fleet_x unchanged.
  - Left with fleet_x == 0: fleet_y += STEP_Y, direction flips to right, fleet_x unchanged.
  - Otherwise fleet_x += 1 (right) or -= 1 (left).
  - fleet_y saturates at SCREEN_H - SPRITE_H.
- State machine:
  - IDLE -> ERASE on erase_req; IDLE -> DRAW on draw_req. If both arrive together, erase wins and draw_req is dropped.
  - DRAW/ERASE each run a SCAN sub-phase: alien index 0..NUM_ALIENS-1, one alien at a time.
  - DRAW covers aliens with alive=1. ERASE covers aliens with alive|dying = 1.
  - An eligible alien emits SPRITE_W*SPRITE_H pixels, one per cycle, row-major from its origin, plot=1. Its first pixel appears the cycle after the request is accepted or after the previous alien finishes.
  - An ineligible alien costs exactly 1 cycle with plot=0.
  - After the last alien: done=1 for one cycle, busy=0, return to IDLE. Pixel port outputs are registered.
  - Requests while busy are ignored.
- Collision (evaluated in IDLE only, when bullet_valid):
  - Alien i is hit if alive[i], bullet_x in [origin_x, origin_x+SPRITE_W-1] and bullet_y in [fleet_y, fleet_y+SPRITE_H-1]. The lowest index wins.
  - Next cycle: alive[i]=0, dying[i]=1, hit=1, hit_index=i.
  - dying is cleared at the end of the next ERASE pass.
  - The same bullet position re-hits nothing, because alive[i] is already 0.
  - A move and a hit in the same cycle both take effect; collision is judged on the pre-move position.
- Arithmetic:
  - Coordinate sums are computed one bit wider and compared unsigned; no wrap.
  - Pixel coordinates beyond SCREEN_W-1 cannot occur, given the edge rule.

Decomposition:
- Shared package holds: the pixel colour constants (COLOUR_BLACK, DRAW_COLOUR), the screen dimensions, the coordinate widths, and the fleet state enum (IDLE, DRAW, ERASE, DONE).
- One natural sub-module: sprite_pixel_scan. Given an origin and a start pulse, it emits SPRITE_W*SPRITE_H row-major coordinates plus a last flag. It is reused by the player and bunker blocks.

Test Plan:
- Reset, then draw_req → 160 plot cycles:
  - pixel 1 at (0,0) colour 101; pixel 10 at (9,0); pixel 11 at (0,1); pixel 41 at (16,0).
  - done is asserted on the cycle after pixel 160, and busy is 0 afterwards.
- From reset, 262 move pulses → fleet_x=262 (R=319). Next move → fleet_y=1, direction left, fleet_x=262. Next move → fleet_x=261.
- In IDLE, bullet_valid with (20,2) → hit=1, hit_index=1, alive=4'b1101. Then:
  - erase_req → 160 plot cycles, colour 000, including alien 1.
  - draw_req → 120 plot cycles plus 1 skip cycle; no pixel in x 16..25.
- draw_req and erase_req in the same cycle → erase pass (colour 000). A draw_req during that pass → ignored; no second pass follows.
- Reset driven 0 at pixel 50 of a draw pass → plot=0 the next cycle, alive=4'b1111, fleet at (0,0), busy=0.
- Bullets at (5,0), (21,0), (37,0), (53,0) in successive IDLE cycles → four hit pulses with indices 0..3; all_dead=1 after the fourth. A bullet at (15,0) (gap between aliens) → no hit.
